// File: rtl/pecell_apb_pkg.sv
// Shared constants for the PE-cell APB register block: register addresses,
// CTRL bit positions and the transfer FSM state type.
package pecell_apb_pkg;

  localparam logic [3:0] ADDR_CTRL     = 4'h0;
  localparam logic [3:0] ADDR_WADDR    = 4'h1;
  localparam logic [3:0] ADDR_STATUS   = 4'h2;
  localparam logic [3:0] ADDR_ID       = 4'h3;
  localparam logic [3:0] ADDR_SCRATCH0 = 4'h4;

  localparam int CTRL_START_BIT = 7;
  localparam int CTRL_MODE_LSB  = 0;
  localparam int CTRL_MODE_W    = 2;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } apb_state_e;

  // Scratch registers occupy 0x4-0x7.
  function automatic logic is_scratch(input logic [3:0] addr);
    return addr[3:2] == ADDR_SCRATCH0[3:2];
  endfunction

endpackage

// File: rtl/pecell_apb_regs_if.sv
// APB bus bundle between the initiator and the PE-cell register block.
// pslverr exists only when PECELL_APB_PSLVERR_EN is defined.
interface pecell_apb_regs_if;

  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;

`ifdef PECELL_APB_PSLVERR_EN
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
`else
  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
`endif

endinterface

// File: rtl/pecell_apb_regs.sv
// APB register block for one PE cell with WAIT_CYCLES wait states per access.
// Define PECELL_APB_PSLVERR_EN to add the pslverr error response.
module pecell_apb_regs
  import pecell_apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            pe_id,
  input  logic                  pe_busy,
  pecell_apb_regs_if.slave      apb,
  output logic [CTRL_MODE_W-1:0] work_mode,
  output logic [4:0]            waddr,
  output logic                  cfg_start
);

  apb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pready_q, pready_d;
  logic [7:0]       prdata_q, prdata_d;
  logic [CTRL_MODE_W-1:0] work_mode_q, work_mode_d;
  logic [4:0]       waddr_q, waddr_d;
  logic             cfg_start_q, cfg_start_d;
  logic [7:0]       scratch_q [4];
  logic [7:0]       scratch_d [4];

  logic             setup;
  logic             access;
  logic             wr_done;
  logic [7:0]       rd_value;

  assign setup   = apb.psel & ~apb.penable;
  assign access  = apb.psel & apb.penable;
  assign wr_done = (state_q == ST_READY) & access & apb.pwrite;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        // penable without a preceding setup cycle is not a transfer start.
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        if (!apb.psel)               state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(1)) state_d = ST_READY;
        else                         cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_READY: begin
        if (!apb.psel || access) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_value = '0;
    case (apb.paddr)
      ADDR_CTRL:   rd_value = {{(8-CTRL_MODE_W){1'b0}}, work_mode_q};
      ADDR_WADDR:  rd_value = {3'b000, waddr_q};
      ADDR_STATUS: rd_value = {7'b0000000, pe_busy};
      ADDR_ID:     rd_value = {1'b0, pe_id};
      default:     if (is_scratch(apb.paddr)) rd_value = scratch_q[apb.paddr[1:0]];
    endcase
  end

  always_comb begin
    pready_d    = (state_d == ST_READY);
    prdata_d    = '0;
    work_mode_d = work_mode_q;
    waddr_d     = waddr_q;
    cfg_start_d = 1'b0;
    scratch_d   = scratch_q;

    // Read data is captured once, on entry to READY, and held until completion.
    if (state_d == ST_READY) prdata_d = (state_q == ST_READY) ? prdata_q : rd_value;

    if (wr_done) begin
      if (apb.paddr == ADDR_CTRL && !pe_busy) begin
        work_mode_d = apb.pwdata[CTRL_MODE_LSB +: CTRL_MODE_W];
        cfg_start_d = apb.pwdata[CTRL_START_BIT];
      end
      if (apb.paddr == ADDR_WADDR)  waddr_d = apb.pwdata[4:0];
      if (is_scratch(apb.paddr))    scratch_d[apb.paddr[1:0]] = apb.pwdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pready_q    <= 1'b0;
      prdata_q    <= '0;
      work_mode_q <= '0;
      waddr_q     <= '0;
      cfg_start_q <= 1'b0;
      // NOTE: the scratch array is a handful of flops, not a RAM, so it is reset like any register.
      scratch_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pready_q    <= pready_d;
      prdata_q    <= prdata_d;
      work_mode_q <= work_mode_d;
      waddr_q     <= waddr_d;
      cfg_start_q <= cfg_start_d;
      scratch_q   <= scratch_d;
    end
  end

  assign apb.pready  = pready_q;
  assign apb.prdata  = prdata_q;
  assign work_mode   = work_mode_q;
  assign waddr       = waddr_q;
  assign cfg_start   = cfg_start_q;

`ifdef PECELL_APB_PSLVERR_EN
  logic err_cond;

  // Error is judged on the same inputs that decide the write at the completion edge.
  assign err_cond = apb.paddr[3]
                  | (apb.pwrite & ((apb.paddr == ADDR_STATUS) | (apb.paddr == ADDR_ID)))
                  | (apb.pwrite & (apb.paddr == ADDR_CTRL) & pe_busy);
  assign apb.pslverr = pready_q & err_cond;
`endif

endmodule

// File: tb/tb_pecell_apb_regs.sv
// Scoreboard bench for pecell_apb_regs: three instances (0, 3 and 2 wait states)
// share one stimulus bus; each transfer queues its expected response.
module tb_pecell_apb_regs;
  import pecell_apb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] pe_id;
  logic       pe_busy;
  logic [2:0] psel_v;
  logic       penable, pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;

  logic [2:0] pready_v;
  logic [7:0] prdata_v [3];
  logic [1:0] work_mode_v [3];
  logic [4:0] waddr_v [3];
  logic [2:0] cfg_start_v;
`ifdef PECELL_APB_PSLVERR_EN
  logic [2:0] pslverr_v;
`endif

  typedef struct packed {
    logic       is_rd;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t  sb_q  [$];
  string tag_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  pecell_apb_regs_if bus0 ();
  pecell_apb_regs_if bus3 ();
  pecell_apb_regs_if bus2 ();

  assign bus0.psel = psel_v[0];  assign bus3.psel = psel_v[1];  assign bus2.psel = psel_v[2];
  assign bus0.penable = penable; assign bus3.penable = penable; assign bus2.penable = penable;
  assign bus0.pwrite = pwrite;   assign bus3.pwrite = pwrite;   assign bus2.pwrite = pwrite;
  assign bus0.paddr = paddr;     assign bus3.paddr = paddr;     assign bus2.paddr = paddr;
  assign bus0.pwdata = pwdata;   assign bus3.pwdata = pwdata;   assign bus2.pwdata = pwdata;
  assign pready_v = {bus2.pready, bus3.pready, bus0.pready};
  assign prdata_v[0] = bus0.prdata;
  assign prdata_v[1] = bus3.prdata;
  assign prdata_v[2] = bus2.prdata;
`ifdef PECELL_APB_PSLVERR_EN
  assign pslverr_v = {bus2.pslverr, bus3.pslverr, bus0.pslverr};
`endif

  pecell_apb_regs #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .pe_id(pe_id), .pe_busy(pe_busy), .apb(bus0),
    .work_mode(work_mode_v[0]), .waddr(waddr_v[0]), .cfg_start(cfg_start_v[0])
  );
  pecell_apb_regs #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .pe_id(pe_id), .pe_busy(pe_busy), .apb(bus3),
    .work_mode(work_mode_v[1]), .waddr(waddr_v[1]), .cfg_start(cfg_start_v[1])
  );
  pecell_apb_regs #(.WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .pe_id(pe_id), .pe_busy(pe_busy), .apb(bus2),
    .work_mode(work_mode_v[2]), .waddr(waddr_v[2]), .cfg_start(cfg_start_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Completion monitor: pops the expected response on the access cycle with pready.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (psel_v[d] && penable && pready_v[d]) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_t  e;
          string t;
          e = sb_q.pop_front();
          t = tag_q.pop_front();
          if (e.is_rd) check({t, "_rdata"}, 32'(prdata_v[d]), 32'(e.rd));
`ifdef PECELL_APB_PSLVERR_EN
          check({t, "_pslverr"}, 32'(pslverr_v[d]), 32'(e.err));
`endif
        end
      end
    end
  end

  task automatic apb_xfer(input int d, input string tag, input bit wr, input logic [3:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd, input bit exp_err,
                          input int exp_wait);
    int waits;
    exp_t e;
    e.is_rd = !wr;
    e.rd    = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    psel_v    = 3'b000;
    psel_v[d] = 1'b1;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = wdata;
    penable   = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    waits   = 0;
    while (!pready_v[d] && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    check({tag, "_waits"}, 32'(waits), 32'(exp_wait));
    if (!pready_v[d]) begin
      void'(sb_q.pop_back());
      void'(tag_q.pop_back());
    end
    @(posedge clk); #1;
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pe_id = 7'h00; pe_busy = 1'b0;
    psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_pready",    32'(pready_v),       32'd0);
    check("rst_prdata",    32'(prdata_v[0]),    32'd0);
    check("rst_work_mode", 32'(work_mode_v[0]), 32'd0);
    check("rst_waddr",     32'(waddr_v[2]),     32'd0);
    check("rst_cfg_start", 32'(cfg_start_v),    32'd0);

    // Zero wait states: WADDR round trip.
    apb_xfer(0, "w0_wr_waddr", 1'b1, 4'h1, 8'h1F, 8'h00, 1'b0, 0);
    check("w0_waddr_out", 32'(waddr_v[0]), 32'h1F);
    apb_xfer(0, "w0_rd_waddr", 1'b0, 4'h1, 8'h00, 8'h1F, 1'b0, 0);

    // CTRL write with start: mode change and a single-cycle pulse.
    apb_xfer(0, "w0_wr_ctrl", 1'b1, 4'h0, 8'h82, 8'h00, 1'b0, 0);
    check("ctrl_work_mode", 32'(work_mode_v[0]), 32'h2);
    check("ctrl_start_hi",  32'(cfg_start_v[0]), 32'd1);
    @(posedge clk); #1;
    check("ctrl_start_lo",  32'(cfg_start_v[0]), 32'd0);
    apb_xfer(0, "w0_rd_ctrl", 1'b0, 4'h0, 8'h00, 8'h02, 1'b0, 0);

    // CTRL write while busy is dropped entirely.
    pe_busy = 1'b1;
    apb_xfer(0, "w0_wr_ctrl_busy", 1'b1, 4'h0, 8'h83, 8'h00, 1'b1, 0);
    check("busy_start_lo",  32'(cfg_start_v[0]), 32'd0);
    check("busy_work_mode", 32'(work_mode_v[0]), 32'h2);
    apb_xfer(0, "w0_rd_status", 1'b0, 4'h2, 8'h00, 8'h01, 1'b0, 0);
    pe_busy = 1'b0;
    apb_xfer(0, "w0_rd_status_idle", 1'b0, 4'h2, 8'h00, 8'h00, 1'b0, 0);

    // Unmapped space.
    apb_xfer(0, "w0_wr_unmapped", 1'b1, 4'hC, 8'hFF, 8'h00, 1'b1, 0);
    apb_xfer(0, "w0_rd_unmapped", 1'b0, 4'hC, 8'h00, 8'h00, 1'b1, 0);

    // penable without setup must not start a transfer.
    @(posedge clk); #1;
    psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 4'h1; pwdata = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    check("nosetup_pready", 32'(pready_v[0]), 32'd0);
    check("nosetup_prdata", 32'(prdata_v[0]), 32'd0);
    psel_v = 3'b000; penable = 1'b0;
    check("nosetup_waddr",  32'(waddr_v[0]), 32'h1F);

    // Three wait states: ID, read-only write, scratch.
    pe_id = 7'h2A;
    apb_xfer(1, "w3_rd_id",      1'b0, 4'h3, 8'h00, 8'h2A, 1'b0, 3);
    apb_xfer(1, "w3_wr_id",      1'b1, 4'h3, 8'h11, 8'h00, 1'b1, 3);
    apb_xfer(1, "w3_rd_id2",     1'b0, 4'h3, 8'h00, 8'h2A, 1'b0, 3);
    apb_xfer(1, "w3_wr_scr7",    1'b1, 4'h7, 8'hA5, 8'h00, 1'b0, 3);
    apb_xfer(1, "w3_rd_scr7",    1'b0, 4'h7, 8'h00, 8'hA5, 1'b0, 3);
    apb_xfer(1, "w3_rd_scr6",    1'b0, 4'h6, 8'h00, 8'h00, 1'b0, 3);

    // Two wait states: psel dropped in WAIT aborts the write.
    @(posedge clk); #1;
    psel_v = 3'b100; pwrite = 1'b1; paddr = 4'h4; pwdata = 8'h55; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("abort_wait_pready", 32'(pready_v[2]), 32'd0);
    psel_v = 3'b000; penable = 1'b0;
    @(posedge clk); #1;
    check("abort_state",  32'(u_dut2.state_q), 32'(ST_IDLE));
    check("abort_pready", 32'(pready_v[2]),    32'd0);
    apb_xfer(2, "w2_rd_scr4_abort", 1'b0, 4'h4, 8'h00, 8'h00, 1'b0, 2);

    // Reset in the middle of a second write.
    @(posedge clk); #1;
    psel_v = 3'b100; pwrite = 1'b1; paddr = 4'h4; pwdata = 8'h66; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel_v = 3'b000; penable = 1'b0;
    check("rstmid_state",  32'(u_dut2.state_q), 32'(ST_IDLE));
    check("rstmid_pready", 32'(pready_v[2]),    32'd0);
    check("rstmid_prdata", 32'(prdata_v[2]),    32'd0);
    apb_xfer(2, "w2_rd_scr4_rst", 1'b0, 4'h4, 8'h00, 8'h00, 1'b0, 2);
    apb_xfer(0, "w0_rd_waddr_rst", 1'b0, 4'h1, 8'h00, 8'h00, 1'b0, 0);

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pecell_apb_regs.md
PECELL_APB_REGS -- requirements
Module: pecell_apb_regs

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, number of wait-state cycles inserted before pready (0..15).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pe_id  input  7  cell identifier, read-only via register map.
REQ-005 psel, penable, pwrite  input  1 each  APB select/enable/direction from initiator.
REQ-006 paddr  input  4  APB register address; pwdata  input  8  write data.
REQ-007 prdata  output  8  read data; pready  output  1  transfer-complete.
REQ-008 pe_busy  input  1  cell busy status from datapath.
REQ-009 work_mode  output  2  configured mode; waddr  output  5  configured weight address; cfg_start  output  1  one-cycle start pulse.

Function
REQ-010 FSM states IDLE, WAIT, READY; IDLE->WAIT on psel&!penable when WAIT_CYCLES>0, IDLE->READY when WAIT_CYCLES=0.
REQ-011 WAIT loads down-counter with WAIT_CYCLES on entry, decrements each cycle, goes to READY when the counter reaches 1.
REQ-012 pready registered, high only in READY; zero-wait config gives pready in first access cycle.
REQ-013 Transfer completes on the edge with psel&penable&pready; FSM returns to IDLE that edge.
REQ-014 psel deasserted in WAIT or READY -> IDLE next edge, no register update (abort).
REQ-015 Map: 0x0 CTRL RW {start[7] W1-pulse reads 0, work_mode[1:0]}; 0x1 WADDR RW [4:0]; 0x2 STATUS RO {pe_busy[0]}; 0x3 ID RO {0,pe_id[6:0]}; 0x4-0x7 SCRATCH RW 8 bit; 0x8-0xF unmapped, read 0x00, writes ignored.
REQ-016 Writes take effect at the completion edge; unused bits read 0; writes to RO ignored.
REQ-017 CTRL write while pe_busy=1 ignored entirely (no mode change, no cfg_start).
REQ-018 cfg_start high exactly one cycle after an accepted CTRL write with pwdata[7]=1.
REQ-019 prdata registered on entry to READY from current register value; 0x00 whenever pready=0.
REQ-020 penable without a prior setup cycle (IDLE, psel&penable) ignored; FSM stays IDLE.

Reset
REQ-021 rst: FSM IDLE, counter 0, pready 0, prdata 0x00, work_mode 0, waddr 0, cfg_start 0, scratch 0x00.
REQ-022 rst asserted mid-transfer aborts it with no write; the initiator must restart from setup.

Configuration
REQ-023 PECELL_APB_PSLVERR_EN defined: adds output pslverr (1 bit), high with pready for unmapped address, write to RO, or CTRL write while pe_busy; reset 0.
REQ-024 Macro undefined: no pslverr port; the same cases complete silently with pready only.

Structure
REQ-025 Package pecell_apb_pkg holds the address constants, CTRL bit positions and the FSM state enum.
REQ-026 Single module with no sub-module; the wait counter is inline.

Verification
REQ-027 WAIT_CYCLES=0, write 0x1=0x1F then read 0x1 -> pready in first access cycle, prdata=0x1F, waddr=5'h1F.
REQ-028 WAIT_CYCLES=3, read 0x3 with pe_id=7'h2A -> pready after 3 wait cycles, prdata=0x2A.
REQ-029 Write 0x0=0x82, pe_busy=0 -> work_mode=2'b10, cfg_start 1 for one cycle, read 0x0 returns 0x02.
REQ-030 Write 0x0=0x83 with pe_busy=1 -> work_mode unchanged, no cfg_start, pslverr=1 when enabled.
REQ-031 Write 0xC=0xFF then read 0xC -> prdata=0x00, pslverr=1 when enabled.
REQ-032 WAIT_CYCLES=2, write 0x4=0x55 with psel dropped in WAIT, then rst mid-transfer on a second write -> scratch stays 0x00, FSM IDLE, pready 0.
